// File: rtl/red_iterativa_pkg.sv
// Shared types for the sequential iterative comparator: mode codes, FSM states
// and the mode-to-result selection used when a compare completes.
package red_iterativa_pkg;

  localparam logic [1:0] MODE_LE = 2'b00;
  localparam logic [1:0] MODE_LT = 2'b01;
  localparam logic [1:0] MODE_EQ = 2'b10;
  localparam logic [1:0] MODE_GE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic mode_result(input logic [1:0] m, input logic g,
                                       input logic e, input logic l);
    logic z;
    z = 1'b0;
    case (m)
      MODE_LE: z = l | e;
      MODE_LT: z = l;
      MODE_EQ: z = e;
      MODE_GE: z = g | e;
      default: z = 1'b0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/celda_cmp_k.sv
// K-bit comparison cell: the single-bit iterative cell chained K times, MSB first.
// Purely combinational; once e drops, g/l are frozen for the rest of the slice.
module celda_cmp_k #(
  parameter int unsigned K = 1
) (
  input  logic [K-1:0] a_slice,
  input  logic [K-1:0] b_slice,
  input  logic         e_in,
  input  logic         g_in,
  input  logic         l_in,
  output logic         e_out,
  output logic         g_out,
  output logic         l_out
);

  always_comb begin
    e_out = e_in;
    g_out = g_in;
    l_out = l_in;
    for (int i = K - 1; i >= 0; i--) begin
      // g/l update must see e before this bit clears it
      g_out = g_out | (e_out & a_slice[i] & ~b_slice[i]);
      l_out = l_out | (e_out & ~a_slice[i] & b_slice[i]);
      e_out = e_out & ~(a_slice[i] ^ b_slice[i]);
    end
  end

endmodule

// File: rtl/red_iterativa_secuencial.sv
// Sequential MSB-first comparator: scans K bits per clock; done after N/K RUN cycles
// (or at the first differing slice with EARLY_EXIT); start is ignored while busy.
module red_iterativa_secuencial
  import red_iterativa_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned K          = 1,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         Zout,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int unsigned STEPS = N / K;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if (N < 1 || K < 1 || (N % K) != 0) begin : g_bad_param
      $error("red_iterativa_secuencial: N must be >= 1 and a multiple of K");
    end
  endgenerate

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  sa_q, sb_q;
  logic [1:0]    mode_q;
  logic          e_q, g_q, l_q;
  logic          e_n, g_n, l_n;
  logic          load, step, finish;

  celda_cmp_k #(.K(K)) u_celda (
    .a_slice (sa_q[N-1 -: K]),
    .b_slice (sb_q[N-1 -: K]),
    .e_in    (e_q),
    .g_in    (g_q),
    .l_in    (l_q),
    .e_out   (e_n),
    .g_out   (g_n),
    .l_out   (l_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        // early exit fires only on the edge where e first drops
        if (cnt_q == LAST || (EARLY_EXIT && e_q && !e_n)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sa_q   <= '0;
      sb_q   <= '0;
      mode_q <= MODE_LE;
      e_q    <= 1'b1;
      g_q    <= 1'b0;
      l_q    <= 1'b0;
    end else if (load) begin
      cnt_q  <= '0;
      sa_q   <= A;
      sb_q   <= B;
      mode_q <= mode;
      e_q    <= 1'b1;
      g_q    <= 1'b0;
      l_q    <= 1'b0;
    end else if (step) begin
      cnt_q <= cnt_q + CW'(1);
      sa_q  <= sa_q << K;
      sb_q  <= sb_q << K;
      e_q   <= e_n;
      g_q   <= g_n;
      l_q   <= l_n;
    end
  end

  // Results load straight from the cell so they appear together with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt   <= 1'b0;
      eq   <= 1'b1;
      lt   <= 1'b0;
      Zout <= 1'b0;
    end else if (finish) begin
      gt   <= g_n;
      eq   <= e_n;
      lt   <= l_n;
      Zout <= mode_result(mode_q, g_n, e_n, l_n);
    end
  end

endmodule

// File: tb/tb_red_iterativa_secuencial.sv
// Bench: four configurations checked every cycle against a latency/result model,
// plus directed cases with hand-computed expectations.
module tb_red_iterativa_secuencial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start;
  logic [1:0] mode [4];
  logic [7:0] a [4];
  logic [7:0] b [4];
  logic [3:0] busy, done, z, gt, eq, lt;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  red_iterativa_secuencial #(.N(4), .K(1), .EARLY_EXIT(1'b0)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]), .A(a[0][3:0]), .B(b[0][3:0]),
    .busy(busy[0]), .done(done[0]), .Zout(z[0]), .gt(gt[0]), .eq(eq[0]), .lt(lt[0]));
  red_iterativa_secuencial #(.N(4), .K(1), .EARLY_EXIT(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]), .A(a[1][3:0]), .B(b[1][3:0]),
    .busy(busy[1]), .done(done[1]), .Zout(z[1]), .gt(gt[1]), .eq(eq[1]), .lt(lt[1]));
  red_iterativa_secuencial #(.N(8), .K(2), .EARLY_EXIT(1'b0)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode[2]), .A(a[2]), .B(b[2]),
    .busy(busy[2]), .done(done[2]), .Zout(z[2]), .gt(gt[2]), .eq(eq[2]), .lt(lt[2]));
  red_iterativa_secuencial #(.N(4), .K(4), .EARLY_EXIT(1'b0)) d3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .mode(mode[3]), .A(a[3][3:0]), .B(b[3][3:0]),
    .busy(busy[3]), .done(done[3]), .Zout(z[3]), .gt(gt[3]), .eq(eq[3]), .lt(lt[3]));

  function automatic int nn(input int d);
    return (d == 2) ? 8 : 4;
  endfunction
  function automatic int kk(input int d);
    return (d == 2) ? 2 : ((d == 3) ? 4 : 1);
  endfunction
  function automatic bit ee(input int d);
    return d == 1;
  endfunction
  function automatic logic [7:0] msk(input int d);
    return 8'((1 << nn(d)) - 1);
  endfunction

  // Edges spent in RUN: full word, or up to the first differing slice with early exit
  function automatic int mlat(input int d, input logic [7:0] x, input logic [7:0] y);
    int n, k, s;
    logic [7:0] xm, ym;
    n = nn(d); k = kk(d); s = n / k;
    xm = x & msk(d); ym = y & msk(d);
    if (ee(d))
      for (int j = 1; j <= s; j++)
        if ((xm >> (n - j * k)) != (ym >> (n - j * k))) return j;
    return s;
  endfunction

  function automatic logic zf(input logic [1:0] m, input logic g, input logic e, input logic l);
    case (m)
      2'b00:   return l | e;
      2'b01:   return l;
      2'b10:   return e;
      default: return g | e;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 run, 2 done; results committed on entry to done
  int         ph [4];
  int         left [4];
  logic       pg [4], pe [4], pl [4];
  logic [1:0] pm [4];
  logic       mg [4], me [4], ml [4], mz [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 4; d++) begin
        ph[d] <= 0; left[d] <= 0;
        mg[d] <= 1'b0; me[d] <= 1'b1; ml[d] <= 1'b0; mz[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        case (ph[d])
          0: if (start[d]) begin
            ph[d]   <= 1;
            left[d] <= mlat(d, a[d], b[d]);
            pg[d]   <= (a[d] & msk(d)) >  (b[d] & msk(d));
            pe[d]   <= (a[d] & msk(d)) == (b[d] & msk(d));
            pl[d]   <= (a[d] & msk(d)) <  (b[d] & msk(d));
            pm[d]   <= mode[d];
          end
          1: if (left[d] == 1) begin
            ph[d] <= 2;
            mg[d] <= pg[d]; me[d] <= pe[d]; ml[d] <= pl[d];
            mz[d] <= zf(pm[d], pg[d], pe[d], pl[d]);
          end else begin
            left[d] <= left[d] - 1;
          end
          default: ph[d] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("d%0d busy", d), busy[d], ph[d] != 0);
        chk($sformatf("d%0d done", d), done[d], ph[d] == 2);
        chk($sformatf("d%0d gt", d), gt[d], mg[d]);
        chk($sformatf("d%0d eq", d), eq[d], me[d]);
        chk($sformatf("d%0d lt", d), lt[d], ml[d]);
        chk($sformatf("d%0d Zout", d), z[d], mz[d]);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns cycles from start edge to done.
  // Operands and mode are scrambled while busy, which must not affect the result.
  task automatic launch(input int d, input logic [7:0] av, input logic [7:0] bv,
                        input logic [1:0] m, output int lat);
    a[d] = av; b[d] = bv; mode[d] = m; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    lat = 1;
    while (!done[d] && lat < 50) begin
      a[d] = 8'($urandom); b[d] = 8'($urandom); mode[d] = 2'($urandom);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("d%0d done timeout", d), lat < 50, 1);
  endtask

  task automatic directed(input int d, input logic [7:0] av, input logic [7:0] bv,
                          input logic [1:0] m, input int elat, input logic ez,
                          input logic eg, input logic ee_, input logic el);
    int lat;
    launch(d, av, bv, m, lat);
    chk($sformatf("dir d%0d latency", d), lat, elat);
    chk($sformatf("dir d%0d Zout", d), z[d], ez);
    chk($sformatf("dir d%0d gt", d), gt[d], eg);
    chk($sformatf("dir d%0d eq", d), eq[d], ee_);
    chk($sformatf("dir d%0d lt", d), lt[d], el);
    @(negedge clk);
  endtask

  initial begin
    int lat, cnt, n;
    logic [7:0] ra, rb;
    logic [1:0] rm;

    rst_n = 1'b0;
    start = '0;
    for (int d = 0; d < 4; d++) begin a[d] = '0; b[d] = '0; mode[d] = '0; end
    repeat (3) @(negedge clk);
    chk("reset busy", busy[0], 0);
    chk("reset done", done[0], 0);
    chk("reset Zout", z[0], 0);
    chk("reset eq", eq[0], 1);
    chk("reset gt_lt", {gt[0], lt[0]}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    cmp_on = 1'b1;

    directed(0, 8'hF, 8'h4, 2'b00, 5, 0, 1, 0, 0);
    directed(0, 8'h3, 8'h4, 2'b00, 5, 1, 0, 0, 1);
    directed(0, 8'h3, 8'h4, 2'b11, 5, 0, 0, 0, 1);
    directed(0, 8'h0, 8'h0, 2'b00, 5, 1, 0, 1, 0);
    directed(0, 8'h0, 8'h0, 2'b01, 5, 0, 0, 1, 0);
    directed(0, 8'h0, 8'h0, 2'b10, 5, 1, 0, 1, 0);
    directed(0, 8'h0, 8'h0, 2'b11, 5, 1, 0, 1, 0);
    directed(2, 8'h3C, 8'h3D, 2'b01, 5, 1, 0, 0, 1);
    directed(3, 8'h5, 8'h6, 2'b01, 2, 1, 0, 0, 1);

    // Early exit, with start held high through the RUN edge
    a[1] = 8'h8; b[1] = 8'h0; mode[1] = 2'b00; start[1] = 1'b1;
    @(negedge clk);
    chk("ee busy in run", busy[1], 1);
    @(negedge clk);
    start[1] = 1'b0;
    chk("ee done at cycle 2", done[1], 1);
    chk("ee Zout", z[1], 0);
    chk("ee gt", gt[1], 1);
    cnt = 0;
    repeat (6) begin @(negedge clk); if (done[1]) cnt++; end
    chk("ee no second done", cnt, 0);

    // Reset pulse in the middle of a compare
    a[0] = 8'hF; b[0] = 8'h0; mode[0] = 2'b00; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("abort busy", busy[0], 0);
    chk("abort Zout", z[0], 0);
    chk("abort eq", eq[0], 1);
    cnt = 0;
    repeat (8) begin @(negedge clk); if (done[0]) cnt++; end
    chk("abort no done", cnt, 0);
    directed(0, 8'h9, 8'h9, 2'b10, 5, 1, 0, 1, 0);

    // Random compares on every configuration
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 40; i++) begin
        n  = nn(d);
        ra = 8'($urandom) & msk(d);
        case ($urandom_range(0, 2))
          0:       rb = 8'($urandom) & msk(d);
          1:       rb = ra;
          default: rb = ra ^ 8'(1 << $urandom_range(0, n - 1));
        endcase
        rm = 2'($urandom);
        launch(d, ra, rb, rm, lat);
        chk($sformatf("rand d%0d latency", d), lat, mlat(d, ra, rb) + 1);
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/red_iterativa_secuencial.md
Name: red_iterativa_secuencial

Overview:
- Sequential, parametrised successor to the combinational left-to-right iterative comparator network.
- Captures two N-bit words A and B on a start request.
- Scans the words MSB-first, K bits per clock, through one reusable comparison cell.
- Reports a mode-selected relation (A<=B, A<B, A==B, A>=B) with a done pulse.
- Trades area for latency. Used where N is too wide for a single-cycle ripple chain.

Parameters:
- N, 4, word width in bits. Must be >= 1.
- K, 1, bits examined per cycle. N must be an exact multiple of K; elaboration fails otherwise.
- EARLY_EXIT, 0. When 1, scanning stops at the first differing slice.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  2  comparison select: 00 LE, 01 LT, 10 EQ, 11 GE.
- A  input  N  operand A; captured when start is accepted.
- B  input  N  operand B; captured when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.
- Zout  output  1  mode result; valid from done, held until the next done.
- gt  output  1  A>B flag of the last completed compare.
- eq  output  1  A==B flag of the last completed compare.
- lt  output  1  A<B flag of the last completed compare.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; counter = 0; shift registers = 0.
  - busy, done, Zout, gt, lt go to 0; eq goes to 1.
  - Release is synchronous to the next rising edge.
- Derived constants: STEPS = N/K. Counter width = clog2(STEPS), minimum 1.
- IDLE:
  - start=1 at an edge captures A, B and mode, sets the working flags e=1, g=0, l=0, counter=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - Compare the top K bits of the A and B shift registers MSB-first.
  - If e=1 and the slices differ, set g or l according to the first differing bit, and clear e.
  - If e=0, the flags are frozen.
  - Shift both registers left by K; counter increments.
- RUN exit:
  - Go to DONE after the edge where counter == STEPS-1.
  - If EARLY_EXIT=1, also go to DONE after the edge where e first clears.
- DONE, one cycle:
  - done=1.
  - gt, eq, lt and Zout are registered from the working flags on the RUN-exit edge, so they are visible together with done.
  - Zout by mode: LE = l|e; LT = l; EQ = e; GE = g|e.
  - Next edge returns to IDLE.
- Latency: start sampled at edge t gives done high during the cycle after edge t+STEPS. With EARLY_EXIT, it is the cycle after edge t+j, where j is the index (1-based) of the first differing slice.
- start while busy is ignored; no queueing. start held high re-triggers on the first IDLE edge after DONE.
- Changes on A, B or mode during RUN/DONE have no effect.
- Results hold through IDLE until the next done.
- rst_n asserted mid-RUN aborts the compare. No done pulse is issued, and outputs take their reset values.
- N=K: single RUN cycle, so done appears 2 cycles after start.

Decomposition:
- Package red_iterativa_pkg holds:
  - mode constants MODE_LE=2'b00, MODE_LT=2'b01, MODE_EQ=2'b10, MODE_GE=2'b11;
  - FSM state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One combinational sub-module, celda_cmp_k (parameter K):
  - inputs: a_slice, b_slice, e_in, g_in, l_in;
  - outputs: e_out, g_out, l_out;
  - scans MSB-first internally, matching the single-bit iterative cell chained K times.
- The top level holds the FSM, counter, shift registers and output registers.

Test Plan:
- N=4, K=1, EARLY_EXIT=0, mode LE, A=4'b1111, B=4'b0100, start for 1 cycle -> done in the 5th cycle after the start edge; Zout=0, gt=1, eq=0, lt=0.
- Same config, mode LE, A=4'b0011, B=4'b0100 -> Zout=1, lt=1; then mode GE with the same operands -> Zout=0.
- A=4'b0000, B=4'b0000, modes LE/LT/EQ/GE in turn -> Zout=1/0/1/1; eq=1 each time.
- EARLY_EXIT=1, A=4'b1000, B=4'b0000, mode LE -> done 2 cycles after start, Zout=0, gt=1. A start pulse during busy is ignored: no second done.
- N=8, K=2, A=8'h3C, B=8'h3D, mode LT -> done 5 cycles after start, Zout=1, lt=1. Operands changed mid-RUN do not alter the result.
- Start a compare, drop rst_n for 3 ns mid-RUN -> busy=0, done never pulses, Zout=0, eq=1. A fresh start afterwards completes normally.
